// File: rtl/fp_accum.sv
// Iterative single-format floating-point accumulator.
// Sums one group of packed {sign, exponent, mantissa} operands, terminated by in_last,
// and presents the truncated sum in split form on a valid/ready output.
// Each element goes through align, add and normalise, one cycle per step.
// The accumulator therefore takes one element every four cycles.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | ready for an element; operand and last flag captured on accept
//   ALIGN  | shift smaller-exponent significand; handle zero / inf operands
//   ADD    | signed-magnitude add of the aligned significands
//   NORM   | leading-zero normalise, write acc; to DONE when last element
//   DONE   | result presented until out_ready, then acc cleared to +0
module fp_accum #(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] in_fp,
  input  logic                                   in_valid,
  input  logic                                   in_last,
  output logic                                   in_ready,
  output logic                                   out_sign,
  output logic [EXPONENT_WIDTH-1:0]              out_exponent,
  output logic [MANTISSA_WIDTH-1:0]              out_mantissa,
  output logic                                   out_valid,
  input  logic                                   out_ready
);

  localparam int E  = EXPONENT_WIDTH;
  localparam int M  = MANTISSA_WIDTH;
  localparam int SW = M + 2;               // carry bit + hidden bit + stored mantissa
  localparam int LW = $clog2(SW + 1);
  localparam logic [E-1:0] EXP_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_DONE
  } state_t;

  state_t state;

  // captured operand
  logic          op_sign;
  logic [E-1:0]  op_exp;
  logic [M-1:0]  op_mant;
  logic          op_last;

  // running sum; holds inf (exp all-ones, mant 0) once inf_flag is set
  logic          acc_sign;
  logic [E-1:0]  acc_exp;
  logic [M-1:0]  acc_mant;
  logic          inf_flag;

  // pipeline-step registers
  logic          skip;                     // element does not change acc
  logic [SW-1:0] big_sig;
  logic [SW-1:0] small_sig;
  logic          big_sign;
  logic          small_sign;
  logic [E-1:0]  res_exp;
  logic [SW-1:0] sum_sig;
  logic          sum_sign;

  // alignment datapath
  logic [SW-1:0] acc_sig;
  logic [SW-1:0] op_sig;
  logic [SW-1:0] al_big_sig;
  logic [SW-1:0] al_small_sig;
  logic [SW-1:0] al_small_shifted;
  logic          al_big_sign;
  logic          al_small_sign;
  logic [E-1:0]  al_exp;
  logic [E-1:0]  al_diff;

  // add datapath
  logic [SW-1:0] add_sig;
  logic          add_sign;

  // normalise datapath
  logic [LW-1:0] lz;
  logic [E:0]    exp_inc;
  logic          nrm_sign;
  logic [E-1:0]  nrm_exp;
  logic [M-1:0]  nrm_mant;
  logic          nrm_inf;
  logic          fin_sign;
  logic [E-1:0]  fin_exp;
  logic [M-1:0]  fin_mant;

  // Source may only hand over an element while idle and out of reset.
  assign in_ready = rst_n && (state == S_IDLE);

  // Pick the larger-exponent operand and right-shift the other by the exponent gap.
  always_comb begin
    acc_sig = (acc_exp == '0) ? '0 : {2'b01, acc_mant};
    op_sig  = (op_exp  == '0) ? '0 : {2'b01, op_mant};
    if (acc_exp >= op_exp) begin
      al_big_sig    = acc_sig;
      al_big_sign   = acc_sign;
      al_small_sig  = op_sig;
      al_small_sign = op_sign;
      al_exp        = acc_exp;
      al_diff       = acc_exp - op_exp;
    end else begin
      al_big_sig    = op_sig;
      al_big_sign   = op_sign;
      al_small_sig  = acc_sig;
      al_small_sign = acc_sign;
      al_exp        = op_exp;
      al_diff       = op_exp - acc_exp;
    end
    if (al_diff >= E'(SW)) begin
      al_small_shifted = '0;
    end else begin
      al_small_shifted = al_small_sig >> al_diff;
    end
  end

  // Signed-magnitude add; with equal exponents the "small" side may be larger, so compare.
  always_comb begin
    if (big_sign == small_sign) begin
      add_sig  = big_sig + small_sig;
      add_sign = big_sign;
    end else if (big_sig >= small_sig) begin
      add_sig  = big_sig - small_sig;
      add_sign = big_sign;
    end else begin
      add_sig  = small_sig - big_sig;
      add_sign = small_sign;
    end
  end

  // Leading-zero count and renormalisation, including carry-out, overflow and underflow.
  always_comb begin
    lz = '0;
    for (int i = 0; i <= M; i++) begin
      if (sum_sig[i]) lz = LW'(M - i);
    end
    exp_inc  = (E+1)'(res_exp) + (E+1)'(1);
    nrm_sign = sum_sign;
    nrm_exp  = res_exp;
    nrm_mant = sum_sig[M-1:0];
    nrm_inf  = 1'b0;
    if (sum_sig[M+1]) begin
      if (exp_inc >= {1'b0, EXP_MAX}) begin
        nrm_exp  = EXP_MAX;
        nrm_mant = '0;
        nrm_inf  = 1'b1;
      end else begin
        nrm_exp  = exp_inc[E-1:0];
        nrm_mant = sum_sig[M:1];
      end
    end else if (sum_sig == '0) begin
      // exact cancellation is always +0
      nrm_sign = 1'b0;
      nrm_exp  = '0;
      nrm_mant = '0;
    end else if ((E+1)'(res_exp) <= (E+1)'(lz)) begin
      // would land below the normal range: flush to +0
      nrm_sign = 1'b0;
      nrm_exp  = '0;
      nrm_mant = '0;
    end else begin
      nrm_exp  = res_exp - E'(lz);
      nrm_mant = M'(sum_sig << lz);
    end
  end

  // Value written back to acc at the end of NORM: unchanged when the element was skipped.
  always_comb begin
    if (skip) begin
      fin_sign = acc_sign;
      fin_exp  = acc_exp;
      fin_mant = acc_mant;
    end else begin
      fin_sign = nrm_sign;
      fin_exp  = nrm_exp;
      fin_mant = nrm_mant;
    end
  end

  // Sequencer plus all datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      op_sign      <= 1'b0;
      op_exp       <= '0;
      op_mant      <= '0;
      op_last      <= 1'b0;
      acc_sign     <= 1'b0;
      acc_exp      <= '0;
      acc_mant     <= '0;
      inf_flag     <= 1'b0;
      skip         <= 1'b0;
      big_sig      <= '0;
      small_sig    <= '0;
      big_sign     <= 1'b0;
      small_sign   <= 1'b0;
      res_exp      <= '0;
      sum_sig      <= '0;
      sum_sign     <= 1'b0;
      out_sign     <= 1'b0;
      out_exponent <= '0;
      out_mantissa <= '0;
      out_valid    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_sign <= in_fp[E+M];
            op_exp  <= in_fp[E+M-1:M];
            op_mant <= in_fp[M-1:0];
            op_last <= in_last;
            state   <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          big_sig    <= al_big_sig;
          small_sig  <= al_small_shifted;
          big_sign   <= al_big_sign;
          small_sign <= al_small_sign;
          res_exp    <= al_exp;
          if (inf_flag || op_exp == '0) begin
            skip <= 1'b1;
          end else if (op_exp == EXP_MAX) begin
            // first inf/NaN of the group fixes the result sign
            skip     <= 1'b1;
            inf_flag <= 1'b1;
            acc_sign <= op_sign;
            acc_exp  <= EXP_MAX;
            acc_mant <= '0;
          end else begin
            skip <= 1'b0;
          end
          state <= S_ADD;
        end
        S_ADD: begin
          sum_sig  <= add_sig;
          sum_sign <= add_sign;
          state    <= S_NORM;
        end
        S_NORM: begin
          acc_sign <= fin_sign;
          acc_exp  <= fin_exp;
          acc_mant <= fin_mant;
          if (!skip && nrm_inf) inf_flag <= 1'b1;
          if (op_last) begin
            out_sign     <= fin_sign;
            out_exponent <= fin_exp;
            out_mantissa <= fin_mant;
            out_valid    <= 1'b1;
            state        <= S_DONE;
          end else begin
            state <= S_IDLE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc_sign  <= 1'b0;
            acc_exp   <= '0;
            acc_mant  <= '0;
            inf_flag  <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_accum.sv
// Directed bench for fp_accum: table of groups with hand-computed sums, plus
// sequences for output back-pressure and mid-group reset.
module tb_fp_accum;

  localparam int E = 8;
  localparam int M = 23;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   in_fp;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic          out_sign;
  logic [E-1:0]  out_exponent;
  logic [M-1:0]  out_mantissa;
  logic          out_valid;
  logic          out_ready;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    string           name;
    int              n;
    logic [2:0][31:0] d;
    logic [31:0]     res;
  } vec_t;

  vec_t vecs[15];

  always #5 clk = ~clk;

  fp_accum #(.EXPONENT_WIDTH(E), .MANTISSA_WIDTH(M)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_fp        (in_fp),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .out_sign     (out_sign),
    .out_exponent (out_exponent),
    .out_mantissa (out_mantissa),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Hand over one element from a negedge, then check the 3 busy cycles and cycle T+4.
  task automatic send(input logic [31:0] d, input logic last);
    int   k;
    logic busy_ok;
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("ready_before_accept", 32'(in_ready), 32'd1);
    in_fp    = d;
    in_valid = 1'b1;
    in_last  = last;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    busy_ok  = !in_ready && !out_valid;
    @(negedge clk);
    busy_ok  = busy_ok && !in_ready && !out_valid;
    @(negedge clk);
    busy_ok  = busy_ok && !in_ready && !out_valid;
    chk("busy_3_cycles", 32'(busy_ok), 32'd1);
    @(negedge clk);
    chk("in_ready_at_t4", 32'(in_ready), 32'(!last));
    chk("out_valid_at_t4", 32'(out_valid), 32'(last));
  endtask

  // Compare the presented result, then accept it and check the return to idle.
  task automatic collect(input string name, input logic [31:0] res);
    chk(name, {out_sign, out_exponent, out_mantissa}, res);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_to_idle", {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{"t1_7p25_plus_0p375", 2, {32'h0, 32'h3EC00000, 32'h40E80000}, 32'h40F40000};
    vecs[1]  = '{"t2_cancel_to_zero",  3, {32'hC1500000, 32'h40E00000, 32'h40C00000}, 32'h00000000};
    vecs[2]  = '{"t3_65_minus_63",     2, {32'h0, 32'hC27C0000, 32'h42820000}, 32'h40000000};
    vecs[3]  = '{"t4_overflow_inf",    2, {32'h0, 32'h7F7FFFFF, 32'h7F7FFFFF}, 32'h7F800000};
    vecs[4]  = '{"t4_neg_inf_sticky",  2, {32'h0, 32'h3F800000, 32'hFF800000}, 32'hFF800000};
    vecs[5]  = '{"single_3p0",         1, {32'h0, 32'h0, 32'h40400000}, 32'h40400000};
    vecs[6]  = '{"single_denormal",    1, {32'h0, 32'h0, 32'h00400000}, 32'h00000000};
    vecs[7]  = '{"single_neg_zero",    1, {32'h0, 32'h0, 32'h80000000}, 32'h00000000};
    vecs[8]  = '{"one_plus_one",       2, {32'h0, 32'h3F800000, 32'h3F800000}, 32'h40000000};
    vecs[9]  = '{"one_minus_half",     2, {32'h0, 32'hBF000000, 32'h3F800000}, 32'h3F000000};
    vecs[10] = '{"shift_out_of_range", 2, {32'h0, 32'h30800000, 32'h3F800000}, 32'h3F800000};
    vecs[11] = '{"zero_mid_group",     3, {32'hC0200000, 32'h00000000, 32'h40400000}, 32'h3F000000};
    vecs[12] = '{"neg_big_sign",       2, {32'h0, 32'h3F800000, 32'hBFC00000}, 32'hBF000000};
    vecs[13] = '{"equal_exp_op_larger",2, {32'h0, 32'hBFC00000, 32'h3F800000}, 32'hBF000000};
    vecs[14] = '{"truncate_low_bits",  2, {32'h0, 32'h34400000, 32'h3F800000}, 32'h3F800001};

    rst_n     = 1'b0;
    in_fp     = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    @(negedge clk);
    chk("reset_in_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_fields", {out_sign, out_exponent, out_mantissa}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 15; i++) begin
      for (int j = 0; j < vecs[i].n; j++) begin
        send(vecs[i].d[j], (j == vecs[i].n - 1));
      end
      collect(vecs[i].name, vecs[i].res);
    end

    // back-pressure: result and valid held, input ignored while DONE
    send(32'h40400000, 1'b1);
    in_fp    = 32'h3F800000;
    in_valid = 1'b1;
    in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_out_fields", {out_sign, out_exponent, out_mantissa}, 32'h40400000);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    collect("t5_held_result", 32'h40400000);
    send(32'h3F800000, 1'b1);
    collect("t5_acc_cleared", 32'h3F800000);

    // mid-group reset discards the partial sum
    send(32'h40400000, 1'b0);
    send(32'h40400000, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset_mid_fields", {out_sign, out_exponent, out_mantissa}, 32'd0);
    begin
      logic saw_valid;
      saw_valid = 1'b0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        saw_valid = saw_valid | out_valid;
      end
      chk("reset_mid_no_output", 32'(saw_valid), 32'd0);
    end
    send(32'h3F800000, 1'b1);
    collect("t6_after_reset", 32'h3F800000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
